reg_file: RTL and testbench



---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_cell.sv | 28 ++
 rtl/reg_file.sv | 49 ++++
 tb/tb_reg_file.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and types for the datapath register file.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 8;
   localparam int unsigned RF_ADDR_W = 3;
   localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

   typedef logic [RF_DATA_W-1:0] rf_data_t;
   typedef logic [RF_ADDR_W-1:0] rf_adr_t;

endpackage

// File: rtl/rf_cell.sv
// One register of the file: synchronous active-high clear, load on we.
module rf_cell
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] val_d, val_q;

   always_comb begin
      val_d = val_q;
      if (we) val_d = d;
   end

   always_ff @(posedge clk) begin
      if (rst) val_q <= '0;
      else     val_q <= val_d;
   end

   assign q = val_q;

endmodule

// File: rtl/reg_file.sv
// 8x8 register file: synchronous write, combinational read, single shared address.
// Optional write-data forwarding to data_out when RF_WR_BYPASS_EN is defined.
module reg_file
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] reg_adr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0]  we_vec;
   logic [DATA_W-1:0] cell_q [DEPTH];
   logic [DATA_W-1:0] rd_data;

   always_comb begin
      we_vec = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         we_vec[i] = ce && (reg_adr == ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      rf_cell #(.DATA_W(DATA_W)) u_cell (
         .clk (clk),
         .rst (rst),
         .we  (we_vec[g]),
         .d   (data_in),
         .q   (cell_q[g])
      );
   end

   assign rd_data = cell_q[reg_adr];

`ifdef RF_WR_BYPASS_EN
   // A reset edge discards the pending write, so it must not be forwarded either.
   assign data_out = (ce && !rst) ? data_in : rd_data;
`else
   assign data_out = rd_data;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file; expected read values come from an array model of the registers.
module tb_reg_file;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned NR = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic [AW-1:0] reg_adr;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;

   typedef struct {
      logic [DW-1:0] exp;
      string         tag;
   } sb_item_t;

   sb_item_t      sb [$];
   logic [DW-1:0] mdl [NR];
   int            n_vec = 0;
   int            n_err = 0;

   reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .reg_adr  (reg_adr),
      .data_in  (data_in),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   // Expected read value while the given inputs are applied, before the next edge.
   function automatic logic [DW-1:0] model_read(input logic r, input logic c,
                                                input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef RF_WR_BYPASS_EN
      if (c && !r) return d;
`endif
      return mdl[a];
   endfunction

   // Inputs are live for exactly one rising edge: the one that starts the next step.
   task automatic step(input logic r, input logic c, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit chk, input string tag);
      sb_item_t it;
      @(posedge clk);
      #1;
      rst = r; ce = c; reg_adr = a; data_in = d;
      if (chk) begin
         it.exp = model_read(r, c, a, d);
         it.tag = tag;
         sb.push_back(it);
      end
      if (r) begin
         for (int i = 0; i < NR; i++) mdl[i] = '0;
      end else if (c) begin
         mdl[a] = d;
      end
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < NR; i++) step(1'b0, 1'b0, AW'(i), DW'($urandom), 1'b1, tag);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_item_t it;
         it = sb.pop_front();
         n_vec++;
         if (data_out !== it.exp) begin
            n_err++;
            $display("FAIL %s: adr=%0d data_out=%h expected %h", it.tag, reg_adr, data_out, it.exp);
         end
      end
   end

   initial begin
      // First edge applies reset with a competing write request.
      rst = 1'b1; ce = 1'b1; reg_adr = 3'd0; data_in = 8'hFF;
      for (int i = 0; i < NR; i++) mdl[i] = '0;

      sweep("reset_clear");

      step(1'b0, 1'b1, 3'd2, 8'd6, 1'b1, "write_pre");
      step(1'b0, 1'b0, 3'd2, 8'd7, 1'b1, "write_post");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd2, 8'd7, 1'b1, "hold_ce0");
      sweep("after_one_write");

      for (int i = 0; i < NR; i++) step(1'b0, 1'b1, AW'(i), 8'hA0 + DW'(i), 1'b1, "fill");
      sweep("fill_readback");

      step(1'b0, 1'b1, 3'd5, 8'h55, 1'b1, "wr55");
      step(1'b0, 1'b0, 3'd5, 8'h00, 1'b1, "rd55");
      step(1'b1, 1'b1, 3'd5, 8'hAA, 1'b1, "rst_vs_wr");
      sweep("rst_priority");

      step(1'b0, 1'b1, 3'd3, 8'h11, 1'b1, "byp_setup");
      step(1'b0, 1'b1, 3'd3, 8'h22, 1'b1, "byp_pre_edge");
      step(1'b0, 1'b0, 3'd3, 8'h00, 1'b1, "byp_post_edge");

      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
              AW'($urandom), DW'($urandom), 1'b1, "random");
      end
      sweep("final_sweep");
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, "idle");

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d checks pending, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
